// File: rtl/pipelined_shifter_pkg.sv
// Shared types for the pipelined shifter: opcode and fill-type encodings
// carried alongside data through the shift levels.
package pipelined_shifter_pkg;

    typedef enum logic [2:0] {
        OP_LSL = 3'b000,
        OP_LSR = 3'b001,
        OP_ASR = 3'b010,
        OP_ROR = 3'b011,
        OP_ROL = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        FILL_ZERO = 2'b00,
        FILL_SIGN = 2'b01,
        FILL_WRAP = 2'b10
    } fill_e;

    localparam int unsigned OP_W = 3;

    // Codes 101..111 have no shift meaning; such items pass through unchanged.
    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op > OP_ROL);
    endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Request/response bundle between the ALU issue logic (master) and the shifter (slave).
interface pipelined_shifter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             illegal_op;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, illegal_op
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, illegal_op
    );
endinterface

// File: rtl/pipelined_shifter_shift_level.sv
// One conditional right-shift level by DIST plus its pipeline register; the
// level acts on shamt bit log2(DIST) and forwards all side-band state.
module shift_level
    import pipelined_shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DIST    = 1,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               i_en,
    input  logic               i_valid,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  fill_e              i_fill,
    input  logic               i_rev,
    input  logic               i_ovf,
    input  logic               i_ill,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_data,
    output logic [SHAMT_W-1:0] o_shamt,
    output fill_e              o_fill,
    output logic               o_rev,
    output logic               o_ovf,
    output logic               o_ill
);

    localparam int unsigned BIT = $clog2(DIST);

    logic [DIST-1:0]    w_fill;
    logic [WIDTH-1:0]   w_data;

    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_shamt;
    fill_e              r_fill;
    logic               r_rev;
    logic               r_ovf;
    logic               r_ill;

    always_comb begin
        w_fill = '0;
        case (i_fill)
            FILL_SIGN: w_fill = {DIST{i_data[WIDTH-1]}};
            FILL_WRAP: w_fill = i_data[DIST-1:0];
            default:   w_fill = '0;
        endcase
        w_data = i_shamt[BIT] ? {w_fill, i_data[WIDTH-1:DIST]} : i_data;
    end

    // Whole stage clears on reset so the final level presents result=0.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_shamt <= '0;
            r_fill  <= FILL_ZERO;
            r_rev   <= 1'b0;
            r_ovf   <= 1'b0;
            r_ill   <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_data;
            r_shamt <= i_shamt;
            r_fill  <= i_fill;
            r_rev   <= i_rev;
            r_ovf   <= i_ovf;
            r_ill   <= i_ill;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_shamt = r_shamt;
    assign o_fill  = r_fill;
    assign o_rev   = r_rev;
    assign o_ovf   = r_ovf;
    assign o_ill   = r_ill;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter/rotator: input normalisation to a right shift,
// SHAMT_W registered shift levels, output reversal and overflow fill.
module pipelined_shifter
    import pipelined_shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                clr,
    pipelined_shifter_if.slave  bus
);

    localparam int unsigned L = SHAMT_W;

    logic               w_advance;
    logic               w_accept;

    logic [WIDTH-1:0]   w_a_rev;
    logic [WIDTH-1:0]   w_n_data;
    logic [SHAMT_W-1:0] w_n_shamt;
    fill_e              w_n_fill;
    logic               w_n_rev;
    logic               w_n_ovf;
    logic               w_n_ill;
    logic               w_b_hi;

    logic               w_valid [L+1];
    logic [WIDTH-1:0]   w_data  [L+1];
    logic [SHAMT_W-1:0] w_shamt [L+1];
    fill_e              w_fill  [L+1];
    logic               w_rev   [L+1];
    logic               w_ovf   [L+1];
    logic               w_ill   [L+1];

    logic [WIDTH-1:0]   w_last;
    logic [WIDTH-1:0]   w_last_rev;
    logic [WIDTH-1:0]   w_result;

    assign w_advance  = bus.out_ready | ~w_valid[L];
    assign bus.in_ready = w_advance & ~clr;
    assign w_accept   = bus.in_valid & bus.in_ready;
    assign w_b_hi     = |bus.b[WIDTH-1:SHAMT_W];

    // Left shifts and left rotates become right operations on the
    // bit-reversed operand; the reversal is undone at the output.
    always_comb begin
        w_a_rev   = '0;
        w_n_rev   = 1'b0;
        w_n_fill  = FILL_ZERO;
        w_n_ovf   = 1'b0;
        w_n_ill   = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_a_rev[i] = bus.a[WIDTH-1-i];
        end
        case (bus.op)
            OP_LSL: begin
                w_n_rev  = 1'b1;
                w_n_fill = FILL_ZERO;
                w_n_ovf  = w_b_hi;
            end
            OP_LSR: begin
                w_n_fill = FILL_ZERO;
                w_n_ovf  = w_b_hi;
            end
            OP_ASR: begin
                w_n_fill = FILL_SIGN;
                w_n_ovf  = w_b_hi;
            end
            OP_ROR: begin
                w_n_fill = FILL_WRAP;
            end
            OP_ROL: begin
                w_n_rev  = 1'b1;
                w_n_fill = FILL_WRAP;
            end
            default: begin
                w_n_ill  = is_illegal_op(bus.op);
            end
        endcase
        w_n_data  = w_n_rev ? w_a_rev : bus.a;
        w_n_shamt = w_n_ill ? '0 : bus.b[SHAMT_W-1:0];
    end

    assign w_valid[0] = w_accept;
    assign w_data[0]  = w_n_data;
    assign w_shamt[0] = w_n_shamt;
    assign w_fill[0]  = w_n_fill;
    assign w_rev[0]   = w_n_rev;
    assign w_ovf[0]   = w_n_ovf;
    assign w_ill[0]   = w_n_ill;

    for (genvar g = 0; g < L; g++) begin : g_level
        shift_level #(
            .WIDTH   (WIDTH),
            .DIST    (1 << g),
            .SHAMT_W (SHAMT_W)
        ) u_level (
            .clk     (clk),
            .clr     (clr),
            .i_en    (w_advance),
            .i_valid (w_valid[g]),
            .i_data  (w_data[g]),
            .i_shamt (w_shamt[g]),
            .i_fill  (w_fill[g]),
            .i_rev   (w_rev[g]),
            .i_ovf   (w_ovf[g]),
            .i_ill   (w_ill[g]),
            .o_valid (w_valid[g+1]),
            .o_data  (w_data[g+1]),
            .o_shamt (w_shamt[g+1]),
            .o_fill  (w_fill[g+1]),
            .o_rev   (w_rev[g+1]),
            .o_ovf   (w_ovf[g+1]),
            .o_ill   (w_ill[g+1])
        );
    end

    // Sign fill keeps the MSB equal to the captured sign, so an ASR
    // overflow can take its fill straight from the final data word.
    always_comb begin
        w_last     = w_data[L];
        w_last_rev = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_last_rev[i] = w_last[WIDTH-1-i];
        end
        w_result = w_rev[L] ? w_last_rev : w_last;
        if (w_ovf[L]) begin
            w_result = (w_fill[L] == FILL_SIGN) ? {WIDTH{w_last[WIDTH-1]}} : '0;
        end
    end

    assign bus.out_valid  = w_valid[L];
    assign bus.result     = w_result;
    assign bus.illegal_op = w_ill[L];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed and randomized checks of pipelined_shifter against an arithmetic reference model.
module tb_pipelined_shifter;

    localparam int unsigned W = 32;
    localparam int unsigned LAT = 5;

    logic clk;
    logic clr;

    pipelined_shifter_if #(.WIDTH(W)) bus ();

    pipelined_shifter #(.WIDTH(W), .SHAMT_W(LAT)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks;
    int unsigned failures;
    int unsigned cyc;
    logic [32:0] expq [$];
    int unsigned stamps [$];
    logic [31:0] pend_res;
    logic        pend_ill;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [31:0] r;
        logic        ill;
        logic [63:0] d;
        int unsigned k;
        ill = 1'b0;
        k = b % 32;
        case (op)
            3'd0: r = (b >= 32) ? 32'd0 : (a << b);
            3'd1: r = (b >= 32) ? 32'd0 : (a >> b);
            3'd2: r = (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b);
            3'd3: begin d = {a, a} >> k; r = d[31:0]; end
            3'd4: begin d = {a, a} << k; r = d[63:32]; end
            default: begin r = a; ill = 1'b1; end
        endcase
        return {ill, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [32:0] m;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.op = op;
        m = model(a, b, op);
        pend_res = m[31:0];
        pend_ill = m[32];
    endtask

    task automatic drive_exp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                             input logic [31:0] exp, input logic ill);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.op = op;
        pend_res = exp;
        pend_ill = ill;
    endtask

    task automatic drive_rand();
        logic [31:0] b;
        case ($urandom_range(0, 3))
            0:       b = $urandom;
            1:       b = $urandom_range(32, 63);
            default: b = $urandom_range(0, 31);
        endcase
        drive($urandom, b, 3'($urandom_range(0, 7)));
    endtask

    // One clock: account for handshakes seen just before the edge.
    task automatic step();
        logic acc;
        logic cons;
        logic [32:0] e;
        #1;
        acc  = bus.in_valid & bus.in_ready;
        cons = bus.out_valid & bus.out_ready & ~clr;
        if (cons === 1'b1) begin
            checks++;
            assert (expq.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_output observed=%h expected=none", bus.result);
            end
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("result", bus.result, e[31:0]);
                chk("illegal_op", {31'd0, bus.illegal_op}, {31'd0, e[32]});
                stamps.push_back(cyc);
            end
        end
        if (clr) expq.delete();
        if (acc === 1'b1) expq.push_back({pend_ill, pend_res});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int unsigned n;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (expq.size() > 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_empty", expq.size(), 0);
        chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic latency_check(input string tag);
        int unsigned n;
        step();
        bus.in_valid = 1'b0;
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, n, LAT);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        clr = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.op = '0;
        bus.out_ready = 1'b1;
        pend_res = '0;
        pend_ill = 1'b0;

        // Reset state
        step();
        step();
        chk("in_ready_during_clr", {31'd0, bus.in_ready}, 32'd0);
        clr = 1'b0;
        #1;
        chk("in_ready_after_clr", {31'd0, bus.in_ready}, 32'd1);
        chk("out_valid_reset", {31'd0, bus.out_valid}, 32'd0);
        chk("result_reset", bus.result, 32'd0);
        chk("illegal_reset", {31'd0, bus.illegal_op}, 32'd0);

        // Single op latency
        drive_exp(32'h0000_0001, 32'd1, 3'b011, 32'h8000_0000, 1'b0);
        latency_check("latency_first");
        drain();

        // Directed vectors, back to back
        stamps.delete();
        drive_exp(32'h0000_0001, 32'd1,  3'b011, 32'h8000_0000, 1'b0); step();
        drive_exp(32'h1234_5678, 32'd36, 3'b011, 32'h8123_4567, 1'b0); step();
        drive_exp(32'h8000_0000, 32'd4,  3'b010, 32'hF800_0000, 1'b0); step();
        drive_exp(32'h8000_0000, 32'd4,  3'b001, 32'h0800_0000, 1'b0); step();
        drive_exp(32'h8000_0000, 32'd40, 3'b010, 32'hFFFF_FFFF, 1'b0); step();
        drive_exp(32'h8000_0000, 32'd40, 3'b001, 32'h0000_0000, 1'b0); step();
        drive_exp(32'h8000_0001, 32'd1,  3'b000, 32'h0000_0002, 1'b0); step();
        drive_exp(32'h8000_0001, 32'd1,  3'b100, 32'h0000_0003, 1'b0); step();
        drive_exp(32'h8000_0001, 32'd32, 3'b000, 32'h0000_0000, 1'b0); step();
        drive_exp(32'hDEAD_BEEF, 32'd7,  3'b110, 32'hDEAD_BEEF, 1'b1); step();
        drive_exp(32'hA5A5_0F0F, 32'd0,  3'b000, 32'hA5A5_0F0F, 1'b0); step();
        drive_exp(32'h7000_0000, 32'd40, 3'b010, 32'h0000_0000, 1'b0); step();
        drive_exp(32'h1234_5678, 32'd32, 3'b100, 32'h1234_5678, 1'b0); step();
        drain();
        chk("burst_count", stamps.size(), 13);
        for (int i = 1; i < stamps.size(); i++) begin
            chk("burst_consecutive", stamps[i] - stamps[i-1], 1);
        end

        // Backpressure with pipeline full
        for (int i = 0; i < 8; i++) begin
            drive_rand();
            step();
        end
        drive_rand();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("stall_result_held", bus.result, expq[0][31:0]);
        end
        bus.out_ready = 1'b1;
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) drive_rand();
            else bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Reset mid-flight; clr beats a simultaneous input
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            step();
        end
        drive_rand();
        clr = 1'b1;
        #1;
        chk("clr_blocks_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("post_clr_out_valid", {31'd0, bus.out_valid}, 32'd0);
            step();
        end
        drive_exp(32'h8000_0000, 32'd4, 3'b010, 32'hF800_0000, 1'b0);
        latency_check("latency_after_clr");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
